// File: rtl/pmic_sequencer.sv
// PMIC bring-up sequencer: walks a table of I2C register writes, hands each to the
// downstream I2C handler, waits a programmable settle delay, and aborts on timeout or overrun.
//   state     | meaning
//   IDLE      | waiting for i_start
//   FETCH1    | table read latency
//   FETCH2    | latch table entry
//   ISSUE     | o_begin pulse
//   WAIT_DONE | waiting for i_done, timeout running
//   DELAY     | settle delay countdown
//   NEXT      | last-flag / overrun decision
//   DONE      | sequence finished
//   ERROR     | aborted, o_errCode/o_errStep valid
module pmic_sequencer #(
    parameter int MAX_STEPS      = 16,
    parameter int DELAY_TICK     = 1000,
    parameter int TIMEOUT_CYCLES = 65535,
    localparam int IDX_W         = $clog2(MAX_STEPS)
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_start,
    output logic [IDX_W-1:0] o_tableIndex,
    input  logic [31:0]      i_tableEntry,
    output logic             o_begin,
    output logic             o_writeEnable,
    output logic [6:0]       o_i2cAddress,
    output logic [7:0]       o_regAddress,
    output logic [7:0]       o_txData,
    input  logic             i_done,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_error,
    output logic [1:0]       o_errCode,
    output logic [IDX_W-1:0] o_errStep
);

    localparam int DLY_RAW = 8 + $clog2(DELAY_TICK + 1);
    localparam int DLY_W   = (DLY_RAW > 24) ? DLY_RAW : 24;
    localparam int TW      = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH1, S_FETCH2, S_ISSUE, S_WAIT_DONE,
        S_DELAY, S_NEXT, S_DONE, S_ERROR
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [6:0]       addr_q, addr_d;
    logic [7:0]       reg_q, reg_d;
    logic [7:0]       data_q, data_d;
    logic [7:0]       dly_units_q, dly_units_d;
    logic             last_q, last_d;
    logic [DLY_W-1:0] dcnt_q, dcnt_d;
    logic [TW-1:0]    tcnt_q, tcnt_d;
    logic [1:0]       err_code_q, err_code_d;
    logic [IDX_W-1:0] err_step_q, err_step_d;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            addr_q      <= '0;
            reg_q       <= '0;
            data_q      <= '0;
            dly_units_q <= '0;
            last_q      <= 1'b0;
            dcnt_q      <= '0;
            tcnt_q      <= '0;
            err_code_q  <= '0;
            err_step_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            addr_q      <= addr_d;
            reg_q       <= reg_d;
            data_q      <= data_d;
            dly_units_q <= dly_units_d;
            last_q      <= last_d;
            dcnt_q      <= dcnt_d;
            tcnt_q      <= tcnt_d;
            err_code_q  <= err_code_d;
            err_step_q  <= err_step_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        addr_d      = addr_q;
        reg_d       = reg_q;
        data_d      = data_q;
        dly_units_d = dly_units_q;
        last_d      = last_q;
        dcnt_d      = dcnt_q;
        tcnt_d      = tcnt_q;
        err_code_d  = err_code_q;
        err_step_d  = err_step_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (i_start) begin
                    idx_d      = '0;
                    err_code_d = 2'd0;
                    state_d    = S_FETCH1;
                end
            end
            S_FETCH1: state_d = S_FETCH2;
            S_FETCH2: begin
                addr_d      = i_tableEntry[31:25];
                reg_d       = i_tableEntry[24:17];
                data_d      = i_tableEntry[16:9];
                dly_units_d = i_tableEntry[8:1];
                last_d      = i_tableEntry[0];
                state_d     = S_ISSUE;
            end
            S_ISSUE: begin
                // tcnt holds cycles elapsed since o_begin; the ISSUE cycle is the first
                tcnt_d  = TW'(1);
                state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (i_done) begin
                    dcnt_d  = DLY_W'(dly_units_q) * DLY_W'(DELAY_TICK);
                    state_d = S_DELAY;
                end else if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    err_code_d = 2'd1;
                    err_step_d = idx_q;
                    state_d    = S_ERROR;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            S_DELAY: begin
                if (dcnt_q == '0) state_d = S_NEXT;
                else              dcnt_d  = dcnt_q - DLY_W'(1);
            end
            S_NEXT: begin
                if (last_q) begin
                    state_d = S_DONE;
                end else if (idx_q == IDX_W'(MAX_STEPS - 1)) begin
                    err_code_d = 2'd2;
                    err_step_d = idx_q;
                    state_d    = S_ERROR;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = S_FETCH1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign o_tableIndex  = idx_q;
    assign o_begin       = (state_q == S_ISSUE);
    assign o_writeEnable = (state_q == S_ISSUE);
    assign o_i2cAddress  = addr_q;
    assign o_regAddress  = reg_q;
    assign o_txData      = data_q;
    assign o_busy        = !(state_q inside {S_IDLE, S_DONE, S_ERROR});
    assign o_done        = (state_q == S_DONE);
    assign o_error       = (state_q == S_ERROR);
    assign o_errCode     = err_code_q;
    assign o_errStep     = err_step_q;

endmodule

// File: tb/tb_pmic_sequencer.sv
// Directed bench for pmic_sequencer: registered table model, i_done responder, per-scenario tasks.
module tb_pmic_sequencer;
    localparam int DT = 10;
    localparam int TO = 40;

    logic        i_clk = 0;
    logic        i_rstn = 0;
    logic        i_start = 0;
    logic [3:0]  o_tableIndex;
    logic [31:0] i_tableEntry = '0;
    logic        o_begin, o_writeEnable;
    logic [6:0]  o_i2cAddress;
    logic [7:0]  o_regAddress, o_txData;
    logic        i_done = 0;
    logic        o_busy, o_done, o_error;
    logic [1:0]  o_errCode;
    logic [3:0]  o_errStep;

    pmic_sequencer #(.MAX_STEPS(16), .DELAY_TICK(DT), .TIMEOUT_CYCLES(TO)) dut (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_start(i_start),
        .o_tableIndex(o_tableIndex), .i_tableEntry(i_tableEntry),
        .o_begin(o_begin), .o_writeEnable(o_writeEnable),
        .o_i2cAddress(o_i2cAddress), .o_regAddress(o_regAddress), .o_txData(o_txData),
        .i_done(i_done), .o_busy(o_busy), .o_done(o_done), .o_error(o_error),
        .o_errCode(o_errCode), .o_errStep(o_errStep)
    );

    always #5 i_clk = ~i_clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    logic [31:0] tbl [16];
    always @(posedge i_clk) i_tableEntry <= tbl[o_tableIndex];

    int          noresp_step = -1;
    int          resp_lat = 5;
    int          done_at = -1;
    bit          outstanding = 0;
    int          begin_cnt = 0;
    int          dbl_begin = 0;
    int          we_bad = 0;
    int          begin_cyc [128];
    int          done_cyc [128];
    logic [22:0] begin_fld [128];

    // responder: answers i_done resp_lat cycles after each o_begin
    always @(negedge i_clk) begin
        if (!i_rstn) begin
            i_done = 0;
            done_at = -1;
            outstanding = 0;
        end else begin
            i_done = (done_at == cyc);
            if (i_done) begin
                outstanding = 0;
                done_cyc[begin_cnt-1] = cyc;
                done_at = -1;
            end
            if (!o_busy && !o_begin) outstanding = 0;
            if (o_begin) begin
                if (outstanding) dbl_begin++;
                if (!o_writeEnable) we_bad++;
                outstanding = 1;
                begin_cyc[begin_cnt] = cyc;
                begin_fld[begin_cnt] = {o_i2cAddress, o_regAddress, o_txData};
                if (int'(o_tableIndex) != noresp_step) done_at = cyc + resp_lat;
                begin_cnt++;
            end
        end
    end

    function automatic logic [31:0] mk(input logic [6:0] a, input logic [7:0] r,
                                       input logic [7:0] d, input logic [7:0] dl, input logic l);
        return {a, r, d, dl, l};
    endfunction

    task automatic load_three();
        for (int i = 0; i < 16; i++) tbl[i] = 32'h0;
        tbl[0] = mk(7'h60, 8'h01, 8'h80, 8'd2, 1'b0);
        tbl[1] = mk(7'h60, 8'h02, 8'h3C, 8'd0, 1'b0);
        tbl[2] = mk(7'h61, 8'h10, 8'h05, 8'd0, 1'b1);
    endtask

    task automatic pulse_start(output int s_cyc);
        @(negedge i_clk);
        i_start = 1;
        s_cyc = cyc;
        @(negedge i_clk);
        i_start = 0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (o_busy && n < budget) begin
            @(negedge i_clk);
            n++;
        end
        checks++;
        if (o_busy) begin
            errors++;
            $display("FAIL %s: still busy after %0d cycles, required idle", name, budget);
        end
    endtask

    task automatic wait_begins(input int target, input int budget, input string name);
        int n = 0;
        while (begin_cnt < target && n < budget) begin
            @(negedge i_clk);
            n++;
        end
        checks++;
        if (begin_cnt < target) begin
            errors++;
            $display("FAIL %s: saw %0d o_begin pulses, required %0d", name, begin_cnt, target);
        end
    endtask

    task automatic test_reset();
        i_rstn = 0;
        #12;
        checks++;
        if ({o_begin, o_writeEnable, o_busy, o_done, o_error, o_errCode, o_errStep,
             o_tableIndex, o_i2cAddress, o_regAddress, o_txData} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got begin=%b busy=%b done=%b err=%b idx=%0d, required all 0",
                     o_begin, o_busy, o_done, o_error, o_tableIndex);
        end
        @(negedge i_clk);
        i_rstn = 1;
        repeat (3) @(negedge i_clk);
    endtask

    task automatic test_three_entry();
        int base, s;
        logic [22:0] exp_fld [3];
        exp_fld[0] = {7'h60, 8'h01, 8'h80};
        exp_fld[1] = {7'h60, 8'h02, 8'h3C};
        exp_fld[2] = {7'h61, 8'h10, 8'h05};
        load_three();
        noresp_step = -1;
        resp_lat = 5;
        base = begin_cnt;
        pulse_start(s);
        wait_idle(1000, "three_idle");
        checks++;
        if (begin_cnt - base !== 3) begin
            errors++;
            $display("FAIL three_count: got %0d begins, required 3", begin_cnt - base);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (begin_fld[base+i] !== exp_fld[i]) begin
                errors++;
                $display("FAIL three_fields[%0d]: got %h, required %h", i, begin_fld[base+i], exp_fld[i]);
            end
        end
        // o_begin lands in the fourth cycle counting the i_start cycle
        checks++;
        if (begin_cyc[base] - s !== 3) begin
            errors++;
            $display("FAIL start_latency: got %0d, required 3", begin_cyc[base] - s);
        end
        // 2*DT+4 idle cycles between step 0's i_done and step 1's o_begin
        checks++;
        if (begin_cyc[base+1] - done_cyc[base] !== 2*DT + 5) begin
            errors++;
            $display("FAIL delay_gap: got %0d, required %0d", begin_cyc[base+1] - done_cyc[base], 2*DT + 5);
        end
        checks++;
        if (begin_cyc[base+2] - done_cyc[base+1] !== 5) begin
            errors++;
            $display("FAIL zero_delay_gap: got %0d, required 5", begin_cyc[base+2] - done_cyc[base+1]);
        end
        checks++;
        if ({o_done, o_busy, o_error, o_errCode} !== 5'b10000) begin
            errors++;
            $display("FAIL three_final: got done=%b busy=%b err=%b code=%0d, required 1 0 0 0",
                     o_done, o_busy, o_error, o_errCode);
        end
    endtask

    task automatic test_timeout();
        int base, s, b1;
        load_three();
        noresp_step = 1;
        resp_lat = 5;
        base = begin_cnt;
        pulse_start(s);
        wait_begins(base + 2, 500, "timeout_begins");
        b1 = begin_cyc[base+1];
        while (cyc < b1 + TO - 1) @(negedge i_clk);
        checks++;
        if (o_error !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early: got o_error=%b one cycle early, required 0", o_error);
        end
        @(negedge i_clk);
        checks++;
        if ({o_error, o_errCode, o_errStep} !== {1'b1, 2'd1, 4'd1}) begin
            errors++;
            $display("FAIL timeout_report: got err=%b code=%0d step=%0d, required 1 1 1",
                     o_error, o_errCode, o_errStep);
        end
        repeat (60) @(negedge i_clk);
        checks++;
        if (begin_cnt - base !== 2) begin
            errors++;
            $display("FAIL timeout_no_more_begin: got %0d begins, required 2", begin_cnt - base);
        end
        noresp_step = -1;
    endtask

    task automatic test_overrun();
        int base, s, n;
        bit wrap, seen_nz;
        for (int i = 0; i < 16; i++) tbl[i] = mk(7'h20 + 7'(i), 8'(i), 8'hA0 + 8'(i), 8'd0, 1'b0);
        base = begin_cnt;
        wrap = 0;
        seen_nz = 0;
        n = 0;
        pulse_start(s);
        while (o_busy && n < 2000) begin
            if (o_tableIndex != 0) seen_nz = 1;
            else if (seen_nz) wrap = 1;
            @(negedge i_clk);
            n++;
        end
        checks++;
        if (o_busy) begin
            errors++;
            $display("FAIL overrun_idle: still busy after 2000 cycles, required idle");
        end
        checks++;
        if (begin_cnt - base !== 16) begin
            errors++;
            $display("FAIL overrun_count: got %0d begins, required 16", begin_cnt - base);
        end
        checks++;
        if ({o_error, o_errCode, o_errStep} !== {1'b1, 2'd2, 4'd15}) begin
            errors++;
            $display("FAIL overrun_report: got err=%b code=%0d step=%0d, required 1 2 15",
                     o_error, o_errCode, o_errStep);
        end
        checks++;
        if (wrap !== 1'b0 || o_tableIndex !== 4'd15) begin
            errors++;
            $display("FAIL overrun_wrap: got wrap=%b idx=%0d, required 0 15", wrap, o_tableIndex);
        end
    endtask

    task automatic test_start_while_busy();
        int base, s;
        load_three();
        base = begin_cnt;
        pulse_start(s);
        wait_begins(base + 2, 500, "busy_begins");
        pulse_start(s);
        wait_idle(1000, "busy_idle");
        checks++;
        if (begin_cnt - base !== 3 || begin_fld[base+2] !== {7'h61, 8'h10, 8'h05} || o_done !== 1'b1) begin
            errors++;
            $display("FAIL start_ignored: got %0d begins last=%h done=%b, required 3 %h 1",
                     begin_cnt - base, begin_fld[base+2], o_done, {7'h61, 8'h10, 8'h05});
        end
        base = begin_cnt;
        pulse_start(s);
        checks++;
        if (o_done !== 1'b0 || o_tableIndex !== 4'd0 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL restart: got done=%b idx=%0d busy=%b, required 0 0 1", o_done, o_tableIndex, o_busy);
        end
        wait_idle(1000, "restart_idle");
        checks++;
        if (begin_cnt - base !== 3 || begin_fld[base] !== {7'h60, 8'h01, 8'h80}) begin
            errors++;
            $display("FAIL restart_seq: got %0d begins first=%h, required 3 %h",
                     begin_cnt - base, begin_fld[base], {7'h60, 8'h01, 8'h80});
        end
    endtask

    task automatic test_reset_mid();
        int base, s;
        load_three();
        base = begin_cnt;
        pulse_start(s);
        wait_begins(base + 1, 200, "rstmid_begin");
        while (cyc < begin_cyc[base] + 10) @(negedge i_clk);
        #2;
        i_rstn = 0;
        #1;
        checks++;
        if ({o_begin, o_writeEnable, o_busy, o_done, o_error, o_errCode, o_errStep,
             o_tableIndex, o_i2cAddress, o_regAddress, o_txData} !== '0) begin
            errors++;
            $display("FAIL rstmid_outputs: got busy=%b addr=%h reg=%h data=%h, required all 0",
                     o_busy, o_i2cAddress, o_regAddress, o_txData);
        end
        @(negedge i_clk);
        #2;
        i_rstn = 1;
        repeat (40) @(negedge i_clk);
        checks++;
        if (begin_cnt - base !== 1 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_quiet: got %0d begins busy=%b, required 1 0", begin_cnt - base, o_busy);
        end
        pulse_start(s);
        wait_idle(1000, "rstmid_recover");
        checks++;
        if (begin_cnt - base !== 4 || o_done !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_recover: got %0d begins done=%b, required 4 1", begin_cnt - base, o_done);
        end
    endtask

    task automatic test_timeout_boundary();
        int base, s;
        load_three();
        resp_lat = TO - 1;
        base = begin_cnt;
        pulse_start(s);
        wait_idle(2000, "boundary_idle");
        checks++;
        if (begin_cnt - base !== 3 || o_error !== 1'b0 || o_done !== 1'b1) begin
            errors++;
            $display("FAIL timeout_boundary: got %0d begins err=%b done=%b, required 3 0 1",
                     begin_cnt - base, o_error, o_done);
        end
        resp_lat = 5;
    endtask

    task automatic test_protocol();
        checks++;
        if (dbl_begin !== 0 || we_bad !== 0) begin
            errors++;
            $display("FAIL begin_protocol: got double=%0d we_low=%0d, required 0 0", dbl_begin, we_bad);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) tbl[i] = 32'h0;
        test_reset();
        test_three_entry();
        test_timeout();
        test_overrun();
        test_start_while_busy();
        test_reset_mid();
        test_timeout_boundary();
        test_protocol();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end
endmodule
